// File: rtl/spi_frame_sequencer_if.sv
// rtl/spi_frame_sequencer_if.sv - SPI pin bundle between the frame sequencer and an ADC.
interface spi_frame_sequencer_if;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs_n, output spi_sclk, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs_n, input spi_sclk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_frame_sequencer.sv
// rtl/spi_frame_sequencer.sv - SPI master issuing one CPOL=0/CPHA=1 frame per start or drdy request.
// A request seen in the last GAP cycle is taken directly, so held requests run back-to-back.
module spi_frame_sequencer #(
  parameter int CLK_DIV    = 6,
  parameter int FRAME_BITS = 32,
  parameter int CS_GAP     = 4
) (
  input  logic                  system_clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  auto_mode,
  input  logic [31:0]           tx_word,
  input  logic                  drdy_n,
  spi_frame_sequencer_if.master spi,
  output logic [31:0]           rx_word,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int SHIFT_CYCLES = 2 * CLK_DIV * FRAME_BITS;
  localparam int CNT_MAX      = (SHIFT_CYCLES > CS_GAP) ? SHIFT_CYCLES : CS_GAP;
  localparam int CNT_W        = $clog2(CNT_MAX + 1);
  localparam int HC_W         = $clog2(CLK_DIV + 1);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
  localparam logic [HC_W-1:0]  HC_LAST    = HC_W'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic [31:0]      tx_sr_q, tx_sr_d;
  logic [31:0]      rx_sr_q, rx_sr_d;
  logic [31:0]      rx_word_q, rx_word_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             rx_valid_q, rx_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             sync1_q, sync2_q, drdy_prev_q;

  logic drdy_fall;
  logic request;
  logic accept;

  assign drdy_fall = drdy_prev_q & ~sync2_q;
  assign request   = start | (auto_mode & drdy_fall);
  assign accept    = request & ((state_q == S_IDLE) || (state_q == S_GAP && cnt_q == GAP_LAST));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hc_d       = hc_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_word_d  = rx_word_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    overrun_d  = auto_mode & drdy_fall & busy_q & ~accept;

    case (state_q)
      S_IDLE: begin
      end
      S_SETUP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          hc_d    = '0;
          sclk_d  = 1'b1;
          mosi_d  = tx_sr_q[31];
          tx_sr_d = {tx_sr_q[30:0], 1'b0};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (hc_q == HC_LAST) begin
          hc_d = '0;
          if (sclk_q) begin
            sclk_d  = 1'b0;
            rx_sr_d = {rx_sr_q[30:0], spi.spi_miso};
          end else if (cnt_q == SHIFT_LAST) begin
            // last low half-period has elapsed; no further rising edge
            state_d = S_HOLD;
            cnt_d   = '0;
            mosi_d  = 1'b0;
          end else begin
            sclk_d  = 1'b1;
            mosi_d  = tx_sr_q[31];
            tx_sr_d = {tx_sr_q[30:0], 1'b0};
          end
        end else begin
          hc_d = hc_q + HC_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == GAP_LAST) begin
          state_d    = S_GAP;
          cnt_d      = '0;
          cs_n_d     = 1'b1;
          rx_word_d  = rx_sr_q;
          rx_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      state_d = S_SETUP;
      cnt_d   = '0;
      hc_d    = '0;
      cs_n_d  = 1'b0;
      sclk_d  = 1'b0;
      mosi_d  = 1'b0;
      busy_d  = 1'b1;
      tx_sr_d = tx_word << (32 - FRAME_BITS);
      rx_sr_d = '0;
    end
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hc_q        <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_word_q   <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      drdy_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hc_q        <= hc_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_word_q   <= rx_word_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      sync1_q     <= drdy_n;
      sync2_q     <= sync1_q;
      drdy_prev_q <= sync2_q;
    end
  end

  assign spi.spi_cs_n = cs_n_q;
  assign spi.spi_sclk = sclk_q;
  assign spi.spi_mosi = mosi_q;
  assign rx_word      = rx_word_q;
  assign rx_valid     = rx_valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// tb/tb_spi_frame_sequencer.sv - randomized scoreboard bench for spi_frame_sequencer.
module tb_spi_frame_sequencer;
  localparam int CD = 6;
  localparam int FB = 32;
  localparam int CG = 4;
  localparam int SHIFT_CYC = 2 * CD * FB;
  localparam int CS_LOW_LEN = CG + SHIFT_CYC + CG;
  localparam int BUSY_LEN = CS_LOW_LEN + CG;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic auto_mode = 1'b0;
  logic drdy_n = 1'b1;
  logic [31:0] tx_word = '0;
  logic [31:0] rx_word;
  logic rx_valid, busy, overrun;

  logic start24 = 1'b0;
  logic [31:0] tx24 = '0;
  logic [31:0] rx_word24;
  logic rx_valid24, busy24, overrun24;

  spi_frame_sequencer_if spi ();
  spi_frame_sequencer_if spi24 ();
  assign spi24.spi_miso = 1'b1;

  spi_frame_sequencer #(.CLK_DIV(CD), .FRAME_BITS(FB), .CS_GAP(CG)) dut (
    .system_clock(clk), .reset_n(reset_n), .start(start), .auto_mode(auto_mode),
    .tx_word(tx_word), .drdy_n(drdy_n), .spi(spi), .rx_word(rx_word),
    .rx_valid(rx_valid), .busy(busy), .overrun(overrun)
  );

  spi_frame_sequencer #(.CLK_DIV(2), .FRAME_BITS(24), .CS_GAP(1)) dut24 (
    .system_clock(clk), .reset_n(reset_n), .start(start24), .auto_mode(1'b0),
    .tx_word(tx24), .drdy_n(1'b1), .spi(spi24), .rx_word(rx_word24),
    .rx_valid(rx_valid24), .busy(busy24), .overrun(overrun24)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tx;
    logic [31:0] miso;
  } frame_t;

  frame_t exp_q[$];
  frame_t e;
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: plays the ADC on MISO and scores each completed frame against the queue.
  logic prev_cs = 1'b1;
  logic prev_sclk = 1'b0;
  logic [31:0] mosi_cap, miso_sr;
  int rises = 0, cs_low = 0, run_len = 0, per_err = 0, setup_err = 0, ovr_cnt = 0;
  bit in_frame = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_frame = 0;
      prev_cs = 1'b1;
      prev_sclk = 1'b0;
      spi.spi_miso = 1'b0;
    end else begin
      if (overrun) ovr_cnt++;
      if (prev_cs && !spi.spi_cs_n) begin
        in_frame = 1;
        rises = 0; cs_low = 0; run_len = 0; per_err = 0; setup_err = 0;
        mosi_cap = '0;
        miso_sr = (exp_q.size() > 0) ? exp_q[0].miso : 32'h0;
        spi.spi_miso = 1'b0;
      end
      if (in_frame && !spi.spi_cs_n) begin
        cs_low++;
        if (spi.spi_sclk != prev_sclk) begin
          if (!spi.spi_sclk && run_len != CD) per_err++;
          if (spi.spi_sclk && rises > 0 && run_len != CD) per_err++;
          run_len = 1;
          if (spi.spi_sclk) begin
            rises++;
            mosi_cap = {mosi_cap[30:0], spi.spi_mosi};
            spi.spi_miso = miso_sr[31];
            miso_sr = {miso_sr[30:0], 1'b0};
          end
        end else begin
          run_len++;
        end
        if (rises == 0 && (spi.spi_sclk || spi.spi_mosi)) setup_err++;
      end
      if (rx_valid) begin
        check("rx_valid_on_cs_rise", {31'b0, (prev_cs == 1'b0) && (spi.spi_cs_n == 1'b1)}, 32'd1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got rx_word %h expected no frame", rx_word);
        end else begin
          e = exp_q.pop_front();
          check("rx_word", rx_word, e.miso);
          check("mosi_word", mosi_cap, e.tx);
          check("sclk_periods", rises, FB);
          check("cs_low_len", cs_low, CS_LOW_LEN);
          check("sclk_half_period_errs", per_err, 0);
          check("setup_idle_errs", setup_err, 0);
        end
        in_frame = 0;
      end
      prev_cs = spi.spi_cs_n;
      prev_sclk = spi.spi_sclk;
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", {31'b0, k < 3000}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, spi.spi_cs_n, 1);
    check({tag, "_sclk"}, spi.spi_sclk, 0);
    check({tag, "_mosi"}, spi.spi_mosi, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_rx_word"}, rx_word, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    logic [31:0] t;
    logic prev24;
    logic [31:0] cap24;
    int rises24;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_rx_word24", rx_word24, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed reference frame
    exp_q.push_back('{32'hA5A5_0F0F, 32'h1234_5678});
    tx_word = 32'hA5A5_0F0F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tx_word = $urandom;
    check("cs_low_1_cycle", spi.spi_cs_n, 0);
    check("busy_on_accept", busy, 1);
    n = 1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check("busy_len", n, BUSY_LEN);
    wait_idle();

    // Random frames with ignored mid-frame start pulses
    for (int i = 0; i < 4; i++) begin
      t = $urandom;
      exp_q.push_back('{t, $urandom});
      tx_word = t;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tx_word = $urandom;
      repeat ($urandom_range(10, 300)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
    end

    // Auto mode: drdy edge starts a frame, second edge mid-frame is an overrun
    auto_mode = 1'b1;
    base = ovr_cnt;
    t = $urandom;
    exp_q.push_back('{t, $urandom});
    tx_word = t;
    drdy_n = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (!spi.spi_cs_n) break;
    end
    check("drdy_to_cs_latency_3_4", {31'b0, (n >= 3) && (n <= 4)}, 32'd1);
    tx_word = $urandom;
    repeat (5) @(negedge clk);
    drdy_n = 1'b1;
    repeat (100) @(negedge clk);
    drdy_n = 1'b0;
    repeat (50) @(negedge clk);
    auto_mode = 1'b0;
    drdy_n = 1'b1;
    wait_idle();
    check("overrun_pulses", ovr_cnt - base, 1);

    // Start and drdy edge pulse in the same IDLE cycle
    auto_mode = 1'b1;
    base = ovr_cnt;
    t = $urandom;
    exp_q.push_back('{t, $urandom});
    tx_word = t;
    drdy_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tx_word = $urandom;
    check("simul_cs_low", spi.spi_cs_n, 0);
    repeat (5) @(negedge clk);
    drdy_n = 1'b1;
    wait_idle();
    check("simul_no_overrun", ovr_cnt - base, 0);
    auto_mode = 1'b0;

    // Start held high: back-to-back frames
    t = $urandom;
    tx_word = t;
    for (int i = 0; i < 3; i++) exp_q.push_back('{t, $urandom});
    start = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      n = 0;
      while (!spi.spi_cs_n && n < 1000) begin
        @(negedge clk);
        n++;
      end
      n = 0;
      while (spi.spi_cs_n && n < 50) begin
        n++;
        @(negedge clk);
      end
      check("b2b_gap", n, CG);
    end
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset during SHIFT bit 10
    t = $urandom;
    exp_q.push_back('{t, $urandom});
    tx_word = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n = 0;
    while (rises < 11 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reached_bit10", {31'b0, n < 1000}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle_cs", spi.spi_cs_n, 1);
    t = $urandom;
    exp_q.push_back('{t, $urandom});
    tx_word = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // 24-bit build, MISO tied high
    tx24 = $urandom;
    start24 = 1'b1;
    @(negedge clk);
    start24 = 1'b0;
    t = tx24;
    tx24 = $urandom;
    rises24 = 0;
    cap24 = '0;
    prev24 = spi24.spi_sclk;
    n = 0;
    while (!rx_valid24 && n < 2000) begin
      if (spi24.spi_sclk && !prev24) begin
        rises24++;
        cap24 = {cap24[30:0], spi24.spi_mosi};
      end
      prev24 = spi24.spi_sclk;
      @(negedge clk);
      n++;
    end
    check("fb24_done", {31'b0, n < 2000}, 32'd1);
    check("fb24_sclk_periods", rises24, 24);
    check("fb24_rx_word", rx_word24, 32'h00FF_FFFF);
    check("fb24_mosi", cap24, {8'h00, t[23:0]});

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
